// File: rtl/tune_pkg.sv
// Shared types, sizes and the note-step table for the tune sequencer.
// Pitch of note i is (freq * STEP[i]) >> 3, so STEP values are multipliers scaled by eight.
package tune_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      PLAY,
      GAP,
      DONE
   } state_t;

   localparam int NUM_NOTES = 8;
   localparam int FREQ_W    = 10;
   localparam int DUR_W     = 10;
   localparam int NOTE_W    = 3;
   localparam int STEP_W    = 5;
   localparam int PITCH_W   = 12;
   localparam int PROD_W    = FREQ_W + STEP_W;

   // Element [0] is the rightmost entry, so the table reads 8,9,10,11,12,13,15,16 by index.
   localparam logic [NUM_NOTES-1:0][STEP_W-1:0] STEP = {
      5'd16, 5'd15, 5'd13, 5'd12, 5'd11, 5'd10, 5'd9, 5'd8
   };

   function automatic logic [PITCH_W-1:0] note_pitch(
      input logic [FREQ_W-1:0] freq,
      input logic [NOTE_W-1:0] idx
   );
      logic [PROD_W-1:0] prod;
      prod = PROD_W'(freq) * PROD_W'(STEP[idx]);
      return prod[PROD_W-1:3];
   endfunction

endpackage

// File: rtl/tune_sequencer_if.sv
// Request/status bundle between the SPI frame logic and the tune sequencer.
interface tune_sequencer_if;
   import tune_pkg::*;

   logic              start;
   logic [FREQ_W-1:0] freq;
   logic [DUR_W-1:0]  dur;
   logic              busy;
   logic              done;
   logic [NOTE_W-1:0] note;
   logic              pwm;

   modport master (
      output start, freq, dur,
      input  busy, done, note, pwm
   );

   modport slave (
      input  start, freq, dur,
      output busy, done, note, pwm
   );

endinterface

// File: rtl/tune_sequencer_nco.sv
// 32-bit phase accumulator whose MSB is a square wave at inc/2^32 of the clock rate.
module tone_nco (
   input  logic        clk,
   input  logic        reset,
   input  logic        clear,
   input  logic        en,
   input  logic [31:0] inc,
   output logic        out
);

   logic [31:0] phase;

   // Clearing outranks stepping so a new note always restarts from phase zero.
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         phase <= '0;
      end else if (en) begin
         phase <= phase + inc;
      end
   end

   assign out = phase[31];

endmodule

// File: rtl/tune_sequencer.sv
// Plays an eight-note melody on pwm from a latched (freq, dur) pair, with
// millisecond-timed notes separated by silent gaps.
module tune_sequencer
   import tune_pkg::*;
#(
   parameter int CLK_HZ     = 24_000_000,
   parameter int TICK_CYC   = CLK_HZ / 1000,
   parameter int INC_PER_HZ = 179,
   parameter int GAP_MS     = 10
)(
   input  logic clk,
   input  logic reset,
   tune_sequencer_if.slave bus
);

   localparam int TICK_W = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_CYC - 1);
   localparam logic [DUR_W-1:0]  GAP_LAST  = DUR_W'(GAP_MS - 1);
   localparam logic [NOTE_W-1:0] LAST_NOTE = NOTE_W'(NUM_NOTES - 1);

   state_t              state;
   state_t              state_nxt;
   logic [FREQ_W-1:0]   freq_q;
   logic [DUR_W-1:0]    dur_q;
   logic [NOTE_W-1:0]   note_q;
   logic [PITCH_W-1:0]  pitch_q;
   logic [TICK_W-1:0]   tick_q;
   logic [DUR_W-1:0]    ms_q;
   logic [DUR_W-1:0]    ms_last;
   logic                seg_end;
   logic                accept;
   logic                nco_clear;
   logic                nco_en;
   logic                nco_out;
   logic [31:0]         phase_inc;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // The same tick/ms counters time both notes and gaps; only the final ms differs.
   always_comb begin
      state_nxt = state;
      ms_last   = (state == PLAY) ? (dur_q - DUR_W'(1)) : GAP_LAST;
      seg_end   = (tick_q == TICK_LAST) && (ms_q == ms_last);
      accept    = 1'b0;
      nco_clear = 1'b1;
      nco_en    = 1'b0;
      bus.busy  = 1'b1;
      bus.done  = 1'b0;
      case (state)
         IDLE: begin
            bus.busy = 1'b0;
            if (bus.start) begin
               accept    = 1'b1;
               state_nxt = LOAD;
            end
         end
         LOAD: begin
            state_nxt = (freq_q == '0 || dur_q == '0) ? DONE : PLAY;
         end
         PLAY: begin
            nco_clear = 1'b0;
            nco_en    = 1'b1;
            if (seg_end) begin
               state_nxt = (note_q == LAST_NOTE) ? DONE : GAP;
            end
         end
         GAP: begin
            if (seg_end) begin
               state_nxt = PLAY;
            end
         end
         DONE: begin
            bus.done  = 1'b1;
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         freq_q  <= '0;
         dur_q   <= '0;
         note_q  <= '0;
         pitch_q <= '0;
         tick_q  <= '0;
         ms_q    <= '0;
      end else begin
         if (accept) begin
            freq_q <= bus.freq;
            dur_q  <= bus.dur;
            note_q <= '0;
         end
         if (state == LOAD) begin
            pitch_q <= note_pitch(freq_q, '0);
         end
         if (state == GAP && seg_end) begin
            note_q  <= note_q + NOTE_W'(1);
            pitch_q <= note_pitch(freq_q, note_q + NOTE_W'(1));
         end
         // Counters run only while timing a note or gap and restart at every segment boundary.
         if (state == PLAY || state == GAP) begin
            if (tick_q == TICK_LAST) begin
               tick_q <= '0;
               ms_q   <= seg_end ? '0 : ms_q + DUR_W'(1);
            end else begin
               tick_q <= tick_q + TICK_W'(1);
            end
         end else begin
            tick_q <= '0;
            ms_q   <= '0;
         end
      end
   end

   assign phase_inc = 32'(pitch_q) * 32'(INC_PER_HZ);

   tone_nco u_nco (
      .clk   (clk),
      .reset (reset),
      .clear (nco_clear),
      .en    (nco_en),
      .inc   (phase_inc),
      .out   (nco_out)
   );

   assign bus.note = note_q;
   assign bus.pwm  = (state == PLAY) && nco_out;

endmodule

// File: tb/tb_tune_sequencer.sv
// Self-checking bench for tune_sequencer: compares every cycle of each melody
// against a timeline computed from note/gap durations and ideal NCO phase arithmetic.
module tb_tune_sequencer;

   localparam int TICK_CYC   = 100;
   localparam int INC_PER_HZ = 42950;
   localparam int GAP_MS     = 1;
   localparam int GAP_CYC    = GAP_MS * TICK_CYC;
   localparam int NOTES      = 8;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;
   int   step_tab [8] = '{8, 9, 10, 11, 12, 13, 15, 16};
   int   rise1 [8];
   int   rise2 [8];

   tune_sequencer_if bus ();

   tune_sequencer #(
      .CLK_HZ     (100_000),
      .TICK_CYC   (TICK_CYC),
      .INC_PER_HZ (INC_PER_HZ),
      .GAP_MS     (GAP_MS)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Expected outputs t cycles after the accepting edge; e_note < 0 means note is not checked.
   function automatic void model(input int f, input int d, input int t,
                                 output logic e_busy, output logic e_done,
                                 output logic e_pwm, output int e_note);
      int play_cyc, seg, total, u, i, r;
      longint inc, ph;
      e_busy = 1'b0;
      e_done = 1'b0;
      e_pwm  = 1'b0;
      e_note = -1;
      if (f == 0 || d == 0) begin
         e_busy = (t <= 1);
         e_done = (t == 1);
         return;
      end
      play_cyc = d * TICK_CYC;
      seg      = play_cyc + GAP_CYC;
      total    = NOTES * play_cyc + (NOTES - 1) * GAP_CYC;
      if (t == 0) begin
         e_busy = 1'b1;
         return;
      end
      u = t - 1;
      if (u < total) begin
         e_busy = 1'b1;
         i      = u / seg;
         r      = u % seg;
         e_note = i;
         if (r < play_cyc) begin
            inc   = longint'((f * step_tab[i]) / 8) * INC_PER_HZ;
            ph    = (longint'(r) * inc) % 64'sd4294967296;
            e_pwm = ph[31];
         end
      end else if (u == total) begin
         e_busy = 1'b1;
         e_done = 1'b1;
         e_note = NOTES - 1;
      end
   endfunction

   task automatic run_melody(input string name, input int f, input int d,
                             input bit scramble, input bit poke);
      string      fname [4] = '{"busy", "done", "note", "pwm"};
      int         bad [4];
      int         ft [4];
      logic [2:0] fg [4];
      logic [2:0] fw [4];
      logic [2:0] got [4];
      logic [2:0] want [4];
      bit         valid [4];
      logic       eb, ed, ep, prev_pwm;
      int         en, end_t, play_cyc, seg, total, u, i, r;
      for (int k = 0; k < 4; k++) begin
         bad[k] = 0;
         ft[k]  = -1;
         fg[k]  = '0;
         fw[k]  = '0;
      end
      for (int k = 0; k < NOTES; k++) begin
         rise1[k] = -1;
         rise2[k] = -1;
      end
      play_cyc = d * TICK_CYC;
      seg      = play_cyc + GAP_CYC;
      total    = (f == 0 || d == 0) ? 0 : NOTES * play_cyc + (NOTES - 1) * GAP_CYC;
      end_t    = (f == 0 || d == 0) ? 1 : total + 1;
      @(posedge clk);
      #1;
      checks++;
      if (bus.busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL %s idle_busy got %b want 0", name, bus.busy);
      end
      bus.start = 1'b1;
      bus.freq  = 10'(f);
      bus.dur   = 10'(d);
      prev_pwm  = 1'b0;
      for (int t = 0; t <= end_t + 3; t++) begin
         @(posedge clk);
         #1;
         model(f, d, t, eb, ed, ep, en);
         got[0] = {2'b0, bus.busy}; want[0] = {2'b0, eb}; valid[0] = 1'b1;
         got[1] = {2'b0, bus.done}; want[1] = {2'b0, ed}; valid[1] = 1'b1;
         got[2] = bus.note;         want[2] = 3'(en);     valid[2] = (en >= 0);
         got[3] = {2'b0, bus.pwm};  want[3] = {2'b0, ep}; valid[3] = 1'b1;
         for (int k = 0; k < 4; k++) begin
            if (valid[k] && got[k] !== want[k]) begin
               if (bad[k] == 0) begin
                  ft[k] = t;
                  fg[k] = got[k];
                  fw[k] = want[k];
               end
               bad[k]++;
            end
         end
         if (t >= 1 && t - 1 < total) begin
            u = t - 1;
            i = u / seg;
            r = u % seg;
            if (r < play_cyc && prev_pwm === 1'b0 && bus.pwm === 1'b1) begin
               if (rise1[i] < 0) rise1[i] = r;
               else if (rise2[i] < 0) rise2[i] = r;
            end
         end
         prev_pwm  = bus.pwm;
         bus.start = 1'b0;
         if (scramble) begin
            bus.freq = 10'($urandom);
            bus.dur  = 10'($urandom);
         end
         if (poke && (t == 3 || t == end_t)) begin
            bus.start = 1'b1;
            bus.freq  = 10'($urandom_range(1, 1023));
            bus.dur   = 10'($urandom_range(1, 3));
         end
      end
      bus.start = 1'b0;
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (bad[k] != 0) begin
            errors++;
            $display("[TB] FAIL %s %s: %0d bad cycles, first at t=%0d got %0d want %0d",
                     name, fname[k], bad[k], ft[k], fg[k], fw[k]);
         end
      end
   endtask

   task automatic test_reset();
      reset     = 1'b1;
      bus.start = 1'b0;
      bus.freq  = '0;
      bus.dur   = '0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.note !== 3'd0 || bus.pwm !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_outputs got busy=%b done=%b note=%0d pwm=%b want 0 0 0 0",
                  bus.busy, bus.done, bus.note, bus.pwm);
      end
      reset = 1'b0;
   endtask

   task automatic test_basic();
      run_melody("basic_f100_d2", 100, 2, 1'b0, 1'b0);
   endtask

   task automatic test_pitch_scale();
      int p7;
      run_melody("scale_f1000_d1", 1000, 1, 1'b0, 1'b0);
      checks++;
      if (rise1[0] < 49 || rise1[0] > 51) begin
         errors++;
         $display("[TB] FAIL note0_half_period got %0d want 50+-1", rise1[0]);
      end
      p7 = rise2[7] - rise1[7];
      checks++;
      if (rise1[7] < 0 || rise2[7] < 0 || p7 < 49 || p7 > 51) begin
         errors++;
         $display("[TB] FAIL note7_period got %0d want 50+-1", p7);
      end
   endtask

   task automatic test_zero_args();
      run_melody("zero_freq", 0, 5, 1'b0, 1'b0);
      run_melody("zero_dur", 300, 0, 1'b0, 1'b0);
   endtask

   task automatic test_ignored_start();
      run_melody("ignore_start", 800, 1, 1'b0, 1'b1);
   endtask

   task automatic test_reset_abort();
      @(posedge clk);
      #1;
      bus.start = 1'b1;
      bus.freq  = 10'd1000;
      bus.dur   = 10'd1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      repeat (3 * (TICK_CYC + GAP_CYC) + 41) @(posedge clk);
      #1;
      checks++;
      if (bus.busy !== 1'b1 || bus.note !== 3'd3 || bus.pwm !== 1'b1) begin
         errors++;
         $display("[TB] FAIL pre_abort got busy=%b note=%0d pwm=%b want 1 3 1",
                  bus.busy, bus.note, bus.pwm);
      end
      reset = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (bus.busy !== 1'b0 || bus.pwm !== 1'b0 || bus.note !== 3'd0 || bus.done !== 1'b0) begin
         errors++;
         $display("[TB] FAIL abort got busy=%b pwm=%b note=%0d done=%b want 0 0 0 0",
                  bus.busy, bus.pwm, bus.note, bus.done);
      end
      reset = 1'b0;
      run_melody("after_abort", 700, 1, 1'b0, 1'b0);
   endtask

   task automatic test_input_scramble();
      run_melody("scramble", 600, 2, 1'b1, 1'b0);
   endtask

   task automatic test_random();
      run_melody("max_freq", 1023, 1, 1'b0, 1'b0);
      for (int n = 0; n < 4; n++) begin
         run_melody("random", int'($urandom_range(1, 1023)), int'($urandom_range(1, 3)),
                    1'b0, 1'b0);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_pitch_scale();
      test_zero_args();
      test_ignored_start();
      test_reset_abort();
      test_input_scramble();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
